// File: rtl/serial_twos_negator_if.sv
// rtl/serial_twos_negator_if.sv - request/result bundle for serial_twos_negator
//
// Purpose: groups the START/MODE/OPERAND request and the BUSY/DONE/RESULT/
// OVERFLOW response of the serial negator into one interface.
// Ports (signals):
//   start     master->slave  1      request, sampled in IDLE or DONE
//   mode      master->slave  2      00 pass, 01 ones' comp, 10 negate, 11 abs
//   operand   master->slave  WIDTH  source value
//   busy      slave->master  1      high while an operation is in flight
//   done      slave->master  1      one-cycle completion pulse
//   result    slave->master  WIDTH  registered result
//   overflow  slave->master  1      most-negative input to negate/abs
interface serial_twos_negator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (
    output start, mode, operand,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, mode, operand,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/serial_twos_negator.sv
// rtl/serial_twos_negator.sv - multi-cycle chunked two's-complement unit
//
// Purpose: pass / ones' complement / negate / absolute value of a WIDTH-bit
// operand, processed CHUNK bits per clock (LSB slice first) with a registered
// carry chain, so no full-width incrementer sits in one cycle.
// Ports:
//   clk    input  rising-edge clock
//   reset  input  synchronous, active-high reset
//   bus    slave  start/mode/operand in, busy/done/result/overflow out
// Parameters: WIDTH (multiple of CHUNK), CHUNK (1..WIDTH).
module serial_twos_negator #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_twos_negator_if.slave   bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] acc_q;
  logic [1:0]       mode_q;
  logic             invert_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;

  int unsigned      base;
  logic [CHUNK-1:0] slice;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] acc_next;
  logic             last_slice;
  logic             invert_new;
  logic             min_neg;

  // abs inverts only negative inputs; negate and ones' complement always do
  always_comb begin
    invert_new = 1'b0;
    case (bus.mode)
      2'b01, 2'b10: invert_new = 1'b1;
      2'b11:        invert_new = bus.operand[WIDTH-1];
      default:      invert_new = 1'b0;
    endcase
  end

  // One slice of the carry chain; the sum is one bit wider so the carry
  // into the next slice falls out of the top bit.
  always_comb begin
    base     = 32'(cnt_q) * 32'(CHUNK);
    slice    = op_q[base +: CHUNK];
    sum      = {1'b0, (invert_q ? ~slice : slice)} + {{CHUNK{1'b0}}, carry_q};
    acc_next = acc_q;
    acc_next[base +: CHUNK] = sum[CHUNK-1:0];
  end

  assign last_slice = (cnt_q == CW'(N - 1));
  assign min_neg    = (op_q == (WIDTH'(1) << (WIDTH - 1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      acc_q      <= '0;
      mode_q     <= 2'b00;
      invert_q   <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q     <= bus.operand;
            mode_q   <= bus.mode;
            invert_q <= invert_new;
            carry_q  <= bus.mode[1] & invert_new;
            cnt_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_RUN: begin
          acc_q   <= acc_next;
          carry_q <= sum[CHUNK];
          if (last_slice) begin
            // final carry-out is dropped: result is modulo 2^WIDTH
            result_q   <= acc_next;
            overflow_q <= mode_q[1] & invert_q & min_neg;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_twos_negator.sv
// tb/tb_serial_twos_negator.sv - self-checking bench for serial_twos_negator
//
// Purpose: drives an 8/4 instance plus 16/1 and 16/16 instances and compares
// against an arithmetic reference model.
// Ports: none (top-level bench).
module tb_serial_twos_negator;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_twos_negator_if #(.WIDTH(8))  bus8  ();
  serial_twos_negator_if #(.WIDTH(16)) bus16a ();
  serial_twos_negator_if #(.WIDTH(16)) bus16b ();

  serial_twos_negator #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );
  serial_twos_negator #(.WIDTH(16), .CHUNK(1)) u_dut16a (
    .clk(clk), .reset(reset), .bus(bus16a)
  );
  serial_twos_negator #(.WIDTH(16), .CHUNK(16)) u_dut16b (
    .clk(clk), .reset(reset), .bus(bus16b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input int w, input logic [1:0] m, input logic [15:0] x);
    logic [15:0] mask;
    logic [15:0] neg;
    mask = 16'((32'h1 << w) - 1);
    neg  = (16'h0 - x) & mask;
    case (m)
      2'b00:   return x & mask;
      2'b01:   return ~x & mask;
      2'b10:   return neg;
      default: return x[w-1] ? neg : (x & mask);
    endcase
  endfunction

  function automatic logic ref_ovf(input int w, input logic [1:0] m, input logic [15:0] x);
    return m[1] && (x == 16'(32'h1 << (w - 1)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op on the 8-bit unit; scrambles inputs while it runs.
  task automatic run_op8(input logic [1:0] m, input logic [7:0] x);
    int lat;
    logic [7:0] exp_r;
    exp_r = 8'(ref_result(8, m, {8'h0, x}));
    bus8.mode = m;
    bus8.operand = x;
    bus8.start = 1'b1;
    tick();
    check("busy_after_accept", 32'(bus8.busy), 32'd1);
    bus8.start   = 1'($urandom_range(0, 1));
    bus8.mode    = 2'($urandom_range(0, 3));
    bus8.operand = 8'($urandom_range(0, 255));
    lat = 0;
    while (lat < 20) begin
      tick();
      bus8.start = 1'b0;
      lat++;
      if (bus8.done) break;
    end
    check("latency8", 32'(lat), 32'd2);
    check("result8", 32'(bus8.result), 32'(exp_r));
    check("ovf8", 32'(bus8.overflow), 32'(ref_ovf(8, m, {8'h0, x})));
    check("busy_at_done", 32'(bus8.busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(bus8.done), 32'd0);
    check("result_stable", 32'(bus8.result), 32'(exp_r));
  endtask

  task automatic run_op16(input logic [1:0] m, input logic [15:0] x);
    int lat_a;
    int lat_b;
    bus16a.mode = m; bus16a.operand = x; bus16a.start = 1'b1;
    bus16b.mode = m; bus16b.operand = x; bus16b.start = 1'b1;
    tick();
    bus16a.start = 1'b0;
    bus16b.start = 1'b0;
    lat_a = 0;
    lat_b = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus16a.done && lat_a == 0) lat_a = c;
      if (bus16b.done && lat_b == 0) lat_b = c;
      if (lat_a != 0 && lat_b != 0) break;
    end
    check("latency16_c1", 32'(lat_a), 32'd16);
    check("latency16_c16", 32'(lat_b), 32'd1);
    check("result16_c1", 32'(bus16a.result), 32'(ref_result(16, m, x)));
    check("result16_c16", 32'(bus16b.result), 32'(ref_result(16, m, x)));
    check("ovf16_c1", 32'(bus16a.overflow), 32'(ref_ovf(16, m, x)));
    check("ovf16_c16", 32'(bus16b.overflow), 32'(ref_ovf(16, m, x)));
    tick();
  endtask

  logic [7:0] ops [0:6];
  int dones;

  initial begin
    bus8.start = 1'b0;   bus8.mode = 2'b00;   bus8.operand = 8'h0;
    bus16a.start = 1'b0; bus16a.mode = 2'b00; bus16a.operand = 16'h0;
    bus16b.start = 1'b0; bus16b.mode = 2'b00; bus16b.operand = 16'h0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_result", 32'(bus8.result), 32'd0);
    check("rst_ovf", 32'(bus8.overflow), 32'd0);

    run_op8(2'b10, 8'h05);
    run_op8(2'b10, 8'h80);
    run_op8(2'b10, 8'h00);
    run_op8(2'b11, 8'hF6);
    run_op8(2'b11, 8'h0A);
    run_op8(2'b11, 8'h80);
    run_op8(2'b01, 8'h3C);
    run_op8(2'b00, 8'h3C);
    run_op8(2'b01, 8'h80);
    for (int i = 0; i < 40; i++)
      run_op8(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

    // START held high: accept every 3 cycles, operand swapped right after accept
    for (int i = 0; i < 7; i++) ops[i] = (i % 2 == 0) ? 8'h11 + 8'(i) : 8'hE0 + 8'(i);
    bus8.mode = 2'b10;
    bus8.operand = ops[0];
    bus8.start = 1'b1;
    tick();
    for (int j = 0; j < 6; j++) begin
      bus8.operand = ops[j+1];
      tick();
      check("b2b_busy", 32'(bus8.busy), 32'd1);
      check("b2b_nodone", 32'(bus8.done), 32'd0);
      tick();
      check("b2b_done", 32'(bus8.done), 32'd1);
      check("b2b_result", 32'(bus8.result), 32'(ref_result(8, 2'b10, {8'h0, ops[j]})));
      if (j == 5) bus8.start = 1'b0;
      tick();
      check("b2b_reaccept", 32'(bus8.busy), (j == 5) ? 32'd0 : 32'd1);
    end

    // reset mid-run abandons the operation silently
    run_op8(2'b10, 8'h05);
    bus8.mode = 2'b10;
    bus8.operand = 8'h21;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(bus8.busy), 32'd0);
    check("midrst_done", 32'(bus8.done), 32'd0);
    check("midrst_result", 32'(bus8.result), 32'd0);
    check("midrst_ovf", 32'(bus8.overflow), 32'd0);
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus8.done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_op8(2'b11, 8'h9C);

    run_op16(2'b10, 16'h0001);
    run_op16(2'b10, 16'h8000);
    run_op16(2'b10, 16'h0000);
    for (int i = 0; i < 6; i++)
      run_op16(2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
